// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package regfile_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int ARB_W        = 8;
  localparam int ARB_D        = 4;
  localparam int ARB_N        = 3;
  localparam int ARB_MAX_LOCK = 8;

  function automatic int unsigned mod_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after start_i, wrapping mod N.
module rr_priority_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  pick_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    int pos;
    pos     = 0;
    pick_o  = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = int'(start_i) + k;
      if (pos >= N) pos = pos - N;
      if (!valid_o && req_i[pos]) begin
        valid_o = 1'b1;
        idx_o   = IW'(pos);
      end
    end
    if (valid_o) pick_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register-file write port with start priority and burst locking.
// Gnt is combinational; WriteEn/Waddr/DataIn are registered one cycle after the grant.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int W        = ARB_W,
  parameter int D        = ARB_D,
  parameter int N        = ARB_N,
  parameter int MAX_LOCK = ARB_MAX_LOCK
) (
  input  logic                 Clk_i,
  input  logic                 Reset_i,
  input  logic                 start_i,
  input  logic [N-1:0]         Req_i,
  input  logic [N-1:0]         Lock_i,
  input  logic [N*D-1:0]       ReqAddr_i,
  input  logic [N*W-1:0]       ReqData_i,
  output logic [N-1:0]         Gnt_o,
  output logic                 WriteEn_o,
  output logic [D-1:0]         Waddr_o,
  output logic [W-1:0]         DataIn_o,
  output logic [$clog2(N)-1:0] LockedOwner_o,
  output logic                 Locked_o
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOCK - 1);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q;
  logic [D-1:0]  waddr_q;
  logic [W-1:0]  wdata_q;

  logic [N-1:0]  rr_pick;
  logic [IW-1:0] rr_idx;
  logic          rr_valid;

  logic [N-1:0]  gnt;
  logic          grant;
  logic [IW-1:0] win;
  logic [D-1:0]  sel_addr;
  logic [W-1:0]  sel_data;

  rr_priority_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i   (Req_i),
    .start_i (ptr_q),
    .pick_o  (rr_pick),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    grant   = 1'b0;
    win     = '0;
    if (Reset_i) begin
      case (state_q)
        IDLE: begin
          if (start_i && Req_i[0]) begin
            grant  = 1'b1;
            win    = '0;
            gnt[0] = 1'b1;
          end else if (rr_valid) begin
            grant = 1'b1;
            win   = rr_idx;
            gnt   = rr_pick;
            ptr_d = IW'(mod_inc(int'(rr_idx), N));
          end
          if (grant && Lock_i[win] && MAX_LOCK > 1) begin
            state_d = LOCKED;
            owner_d = win;
            cnt_d   = CW'(1);
          end
        end
        LOCKED: begin
          if (start_i && Req_i[0] && owner_q != '0) begin
            grant   = 1'b1;
            win     = '0;
            gnt[0]  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            if (Req_i[owner_q]) begin
              grant        = 1'b1;
              win          = owner_q;
              gnt[owner_q] = 1'b1;
            end
            if (!Lock_i[owner_q]) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else if (grant && cnt_q == CNT_LAST) begin
              // Burst has used its full allowance: hand the port on fairly.
              state_d = IDLE;
              cnt_d   = '0;
              ptr_d   = IW'(mod_inc(int'(owner_q), N));
            end else if (grant) begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win == IW'(i)) begin
        sel_addr = ReqAddr_i[i*D +: D];
        sel_data = ReqData_i[i*W +: W];
      end
    end
  end

  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we_q    <= grant;
      if (grant) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
    end
  end

  assign Gnt_o         = gnt;
  assign WriteEn_o     = we_q;
  assign Waddr_o       = waddr_q;
  assign DataIn_o      = wdata_q;
  assign LockedOwner_o = owner_q;
  assign Locked_o      = (state_q == LOCKED);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus forced-release and reset-mid-lock sequences.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [2:0]  Req;
  logic [2:0]  Lock;
  logic [11:0] ReqAddr;
  logic [23:0] ReqData;
  logic [2:0]  Gnt;
  logic        WriteEn;
  logic [3:0]  Waddr;
  logic [7:0]  DataIn;
  logic [1:0]  LockedOwner;
  logic        Locked;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .Clk_i         (clk),
    .Reset_i       (Reset),
    .start_i       (start),
    .Req_i         (Req),
    .Lock_i        (Lock),
    .ReqAddr_i     (ReqAddr),
    .ReqData_i     (ReqData),
    .Gnt_o         (Gnt),
    .WriteEn_o     (WriteEn),
    .Waddr_o       (Waddr),
    .DataIn_o      (DataIn),
    .LockedOwner_o (LockedOwner),
    .Locked_o      (Locked)
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic [2:0] req;
    logic [2:0] lock;
    logic [2:0] gnt;
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic       lkd;
    logic [1:0] own;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic st, input logic [2:0] req,
                              input logic [2:0] lock, input logic [2:0] gnt, input logic we,
                              input logic [3:0] addr, input logic [7:0] data,
                              input logic lkd, input logic [1:0] own);
    vec_t v;
    v.rst = rst; v.st = st; v.req = req; v.lock = lock; v.gnt = gnt;
    v.we = we; v.addr = addr; v.data = data; v.lkd = lkd; v.own = own;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [2:0] q, input logic [2:0] l);
    Reset = r; start = s; Req = q; Lock = l;
    #2;
  endtask

  task automatic expect_out(input string tag, input int idx, input logic [2:0] g, input logic we,
                            input logic [3:0] a, input logic [7:0] d, input logic lk,
                            input logic [1:0] ow);
    chk({tag, ".gnt"}, idx, 32'(Gnt), 32'(g));
    chk({tag, ".we"}, idx, 32'(WriteEn), 32'(we));
    chk({tag, ".waddr"}, idx, 32'(Waddr), 32'(a));
    chk({tag, ".data"}, idx, 32'(DataIn), 32'(d));
    chk({tag, ".locked"}, idx, 32'(Locked), 32'(lk));
    if (lk) chk({tag, ".owner"}, idx, 32'(LockedOwner), 32'(ow));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // requester i: address i+1, data 0x11*(i+1)
    ReqAddr = {4'd3, 4'd2, 4'd1};
    ReqData = {8'h33, 8'h22, 8'h11};
    Reset = 1'b0; start = 1'b0; Req = 3'b111; Lock = 3'b000;
    tick();

    //              rst st req     lock    | gnt     we addr   data   lk own
    vecs.push_back(mk(0, 0, 3'b111, 3'b000, 3'b000, 0, 4'd0, 8'h00, 0, 2'd0));
    vecs.push_back(mk(0, 0, 3'b111, 3'b000, 3'b000, 0, 4'd0, 8'h00, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b111, 3'b000, 3'b001, 0, 4'd0, 8'h00, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b111, 3'b000, 3'b010, 1, 4'd1, 8'h11, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b111, 3'b000, 3'b100, 1, 4'd2, 8'h22, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b111, 3'b000, 3'b001, 1, 4'd3, 8'h33, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b000, 3'b000, 3'b000, 1, 4'd1, 8'h11, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b000, 3'b000, 3'b000, 0, 4'd1, 8'h11, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b010, 3'b000, 3'b010, 0, 4'd1, 8'h11, 0, 2'd0));
    vecs.push_back(mk(1, 1, 3'b101, 3'b000, 3'b001, 1, 4'd2, 8'h22, 0, 2'd0));
    vecs.push_back(mk(1, 1, 3'b101, 3'b000, 3'b001, 1, 4'd1, 8'h11, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b101, 3'b000, 3'b100, 1, 4'd1, 8'h11, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b000, 3'b000, 3'b000, 1, 4'd3, 8'h33, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b110, 3'b010, 3'b010, 0, 4'd3, 8'h33, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b110, 3'b010, 3'b010, 1, 4'd2, 8'h22, 1, 2'd1));
    vecs.push_back(mk(1, 0, 3'b110, 3'b010, 3'b010, 1, 4'd2, 8'h22, 1, 2'd1));
    vecs.push_back(mk(1, 0, 3'b110, 3'b010, 3'b010, 1, 4'd2, 8'h22, 1, 2'd1));
    vecs.push_back(mk(1, 0, 3'b110, 3'b000, 3'b010, 1, 4'd2, 8'h22, 1, 2'd1));
    vecs.push_back(mk(1, 0, 3'b110, 3'b000, 3'b100, 1, 4'd2, 8'h22, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b000, 3'b000, 3'b000, 1, 4'd3, 8'h33, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b010, 3'b010, 3'b010, 0, 4'd3, 8'h33, 0, 2'd0));
    vecs.push_back(mk(1, 1, 3'b011, 3'b010, 3'b001, 1, 4'd2, 8'h22, 1, 2'd1));
    vecs.push_back(mk(1, 0, 3'b000, 3'b000, 3'b000, 1, 4'd1, 8'h11, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b010, 3'b010, 3'b010, 0, 4'd1, 8'h11, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b101, 3'b010, 3'b000, 1, 4'd2, 8'h22, 1, 2'd1));
    vecs.push_back(mk(1, 0, 3'b101, 3'b000, 3'b000, 0, 4'd2, 8'h22, 1, 2'd1));
    vecs.push_back(mk(1, 0, 3'b101, 3'b000, 3'b100, 0, 4'd2, 8'h22, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b000, 3'b000, 3'b000, 1, 4'd3, 8'h33, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b011, 3'b010, 3'b001, 0, 4'd3, 8'h33, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b000, 3'b000, 3'b000, 1, 4'd1, 8'h11, 0, 2'd0));
    vecs.push_back(mk(1, 1, 3'b001, 3'b001, 3'b001, 0, 4'd1, 8'h11, 0, 2'd0));
    vecs.push_back(mk(1, 0, 3'b000, 3'b000, 3'b000, 1, 4'd1, 8'h11, 1, 2'd0));
    vecs.push_back(mk(1, 0, 3'b000, 3'b000, 3'b000, 0, 4'd1, 8'h11, 0, 2'd0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].req, vecs[i].lock);
      expect_out("vec", i, vecs[i].gnt, vecs[i].we, vecs[i].addr, vecs[i].data,
                 vecs[i].lkd, vecs[i].own);
      tick();
    end

    // Forced release: requester 2 locks for exactly 8 grants, then Ptr wraps to 0.
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 3'b101, 3'b100);
      if (k == 0) expect_out("force", k, 3'b100, 0, 4'd1, 8'h11, 0, 2'd0);
      else        expect_out("force", k, 3'b100, 1, 4'd3, 8'h33, 1, 2'd2);
      tick();
    end
    drive(1, 0, 3'b101, 3'b100);
    expect_out("force", 8, 3'b001, 1, 4'd3, 8'h33, 0, 2'd0);
    tick();

    // Reset while locked with a write in flight.
    drive(1, 0, 3'b010, 3'b010);
    expect_out("rstlk", 0, 3'b010, 1, 4'd1, 8'h11, 0, 2'd0);
    tick();
    drive(0, 0, 3'b010, 3'b010);
    expect_out("rstlk", 1, 3'b000, 1, 4'd2, 8'h22, 1, 2'd1);
    tick();
    drive(1, 0, 3'b011, 3'b000);
    expect_out("rstlk", 2, 3'b001, 0, 4'd0, 8'h00, 0, 2'd0);
    tick();
    drive(1, 0, 3'b000, 3'b000);
    expect_out("rstlk", 3, 3'b000, 1, 4'd1, 8'h11, 0, 2'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
